// File: rtl/tdm_mux4_pkg.sv
// Shared constants, FSM encoding and pointer helper for the tdm_mux4 4-to-1 TDM multiplexer.
package tdm_mux4_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Round-robin pointer moves one past the last grant; 2-bit arithmetic wraps 3 -> 0.
    function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/tdm_mux4_rr_arb4.sv
// Combinational 4-way round-robin arbiter: the first requester at or after ptr (mod 4) wins.
module rr_arb4
    import tdm_mux4_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] ptr,
    output logic [NCH-1:0]   grant,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             any
);

    logic [SEL_W-1:0] w_idx;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        any     = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            w_idx = ptr + 2'(k);
            if (!any && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                gnt_idx      = w_idx;
                any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_mux4.sv
// Registered 4-to-1 TDM multiplexer with round-robin arbitration and a 2-bit channel tag.
// Optional per-channel saturating grant counters are enabled by defining TDM_MUX4_STATS_EN.
module tdm_mux4
    import tdm_mux4_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef TDM_MUX4_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 dbg_state,
    input  logic                 out_ready
`ifdef TDM_MUX4_STATS_EN
    ,
    output logic [NCH*CNT_W-1:0] stat_cnt
`endif
);

    // Handshake: a beat moves on a channel in any cycle where valid and ready are both high;
    // in_ready never depends on in_data, and out_valid stays asserted until out_ready takes it.

    state_t           r_state;
    state_t           w_next_state;
    logic [SEL_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_sel;

    logic             w_load;
    logic [NCH-1:0]   w_grant;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_any;

    rr_arb4 u_arb (
        .req     (in_valid),
        .ptr     (r_ptr),
        .grant   (w_grant),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    // Drain and refill may happen in the same cycle, giving one beat per cycle.
    assign w_load = (r_state == EMPTY) | (out_ready & out_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_load) begin
            w_next_state = w_any ? FULL : EMPTY;
        end
    end

    always_comb begin
        out_valid = (r_state == FULL);
        in_ready  = rst ? '0 : (w_grant & {NCH{w_load}});
        dbg_state = r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_sel  <= '0;
            r_ptr  <= '0;
        end else if (w_load && w_any) begin
            r_data <= in_data[int'(w_gnt_idx)*WIDTH +: WIDTH];
            r_sel  <= w_gnt_idx;
            r_ptr  <= next_ptr(w_gnt_idx);
        end
    end

    assign out_data = r_data;
    assign out_sel  = r_sel;

`ifdef TDM_MUX4_STATS_EN
    logic [CNT_W-1:0] r_cnt [NCH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst) begin
                r_cnt[i] <= '0;
            end else if (in_valid[i] && in_ready[i] && (r_cnt[i] != {CNT_W{1'b1}})) begin
                r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_stat
        assign stat_cnt[g*CNT_W +: CNT_W] = r_cnt[g];
    end
`endif

endmodule

// File: tb/tb_tdm_mux4.sv
// Directed self-checking bench for tdm_mux4; also exercises the counters when TDM_MUX4_STATS_EN is defined.
module tb_tdm_mux4;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       in_valid;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]       in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;
    logic             dbg_state;
    logic             out_ready;
`ifdef TDM_MUX4_STATS_EN
    logic [4*CNT_W-1:0] stat_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdm_mux4 #(
        .WIDTH (WIDTH)
`ifdef TDM_MUX4_STATS_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .dbg_state (dbg_state),
        .out_ready (out_ready)
`ifdef TDM_MUX4_STATS_EN
        ,
        .stat_cnt  (stat_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1. reset with all channels requesting
        rst       = 1'b1;
        in_valid  = 4'b1111;
        in_data   = {8'h33, 8'h22, 8'h11, 8'h00};
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready_comb", 32'(in_ready), 32'h0);
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_sel", 32'(out_sel), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'h0);

        // 2. single beat on channel 2
        rst       = 1'b0;
        in_valid  = 4'b0100;
        in_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
        out_ready = 1'b1;
        #1;
        chk("single_in_ready", 32'(in_ready), 32'h4);
        tick();
        in_valid = 4'b0000;
        chk("single_out_valid", 32'(out_valid), 32'h1);
        chk("single_out_data", 32'(out_data), 32'hA5);
        chk("single_out_sel", 32'(out_sel), 32'h2);
        chk("single_state", 32'(dbg_state), 32'h1);
        #1;
        chk("drain_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("drain_out_valid", 32'(out_valid), 32'h0);
        chk("drain_data_held", 32'(out_data), 32'hA5);

        // 3. round-robin from a fresh pointer, all channels requesting, no bubbles
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 4'b1111;
        in_data  = {8'h03, 8'h02, 8'h01, 8'h00};
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
            tick();
            chk("rr_out_valid", 32'(out_valid), 32'h1);
            chk("rr_out_sel", 32'(out_sel), 32'(k % 4));
            chk("rr_out_data", 32'(out_data), 32'(k % 4));
        end

        // 4. backpressure while holding a channel-1 beat (pointer currently 2)
        in_valid = 4'b0010;
        in_data  = {8'h03, 8'h02, 8'h3C, 8'h00};
        #1;
        chk("bp_load_in_ready", 32'(in_ready), 32'h2);
        tick();
        chk("bp_load_sel", 32'(out_sel), 32'h1);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            tick();
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_out_data", 32'(out_data), 32'h3C);
            chk("bp_out_sel", 32'(out_sel), 32'h1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'h4);
        tick();
        chk("bp_next_valid", 32'(out_valid), 32'h1);
        chk("bp_next_sel", 32'(out_sel), 32'h2);
        chk("bp_next_data", 32'(out_data), 32'h02);

        // 5. reset while FULL (pointer currently 3)
        rst       = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'h0);
        tick();
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_state", 32'(dbg_state), 32'h0);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("midrst_first_grant", 32'(in_ready), 32'h1);
        tick();
        chk("midrst_first_sel", 32'(out_sel), 32'h0);
        chk("midrst_first_data", 32'(out_data), 32'h00);

`ifdef TDM_MUX4_STATS_EN
        // 6. counters: 16 channel-3 accepts saturate a 4-bit counter
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("stat_reset", 32'(stat_cnt), 32'h0);
        in_valid  = 4'b1000;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) tick();
        chk("stat_ch3_full", 32'(stat_cnt[3*CNT_W +: CNT_W]), 32'hF);
        chk("stat_others", 32'(stat_cnt[3*CNT_W-1:0]), 32'h0);
        for (int k = 0; k < 3; k++) tick();
        chk("stat_ch3_sat", 32'(stat_cnt[3*CNT_W +: CNT_W]), 32'hF);
        chk("stat_others_sat", 32'(stat_cnt[3*CNT_W-1:0]), 32'h0);
`endif

        in_valid = 4'b0000;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
